// File: rtl/mem_boot_loader.sv
// Boot sequencer: holds the core in reset and streams a length-prefixed image into memory.
// Optional macro BOOT_CHECKSUM_EN adds a trailing checksum byte and an error state.
module mem_boot_loader #(
    parameter int WIDTH     = 8,
    parameter int START_ADR = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             cpu_memwrite,
    input  logic [WIDTH-1:0] cpu_adr,
    input  logic [WIDTH-1:0] cpu_writedata,
    output logic             mem_memwrite,
    output logic [WIDTH-1:0] mem_adr,
    output logic [WIDTH-1:0] mem_writedata,
    output logic             cpu_resetn,
    output logic             busy,
    output logic             err
);

    typedef enum logic [2:0] {
        S_LEN   = 3'd0,
        S_LOAD  = 3'd1,
        S_DRAIN = 3'd2,
        S_RUN   = 3'd3,
        S_CHK   = 3'd4,
        S_ERR   = 3'd5
    } state_t;

`ifdef BOOT_CHECKSUM_EN
    localparam state_t S_AFTER_DATA = S_CHK;
`else
    localparam state_t S_AFTER_DATA = S_DRAIN;
`endif

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       len_q, len_d;
    logic             wr_en_q, wr_en_d;
    logic [WIDTH-1:0] wr_adr_q, wr_adr_d;
    logic [WIDTH-1:0] wr_data_q, wr_data_d;
    logic             cpu_resetn_q, cpu_resetn_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic             xfer_s;
    logic [WIDTH-1:0] load_adr_s;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]       sum_q, sum_d;
    logic [7:0]       chk_sum_s;
`endif

    assign xfer_s     = in_valid && in_ready;
    // Address arithmetic deliberately wraps at 2^WIDTH.
    assign load_adr_s = WIDTH'(START_ADR) + WIDTH'(cnt_q);
`ifdef BOOT_CHECKSUM_EN
    assign chk_sum_s  = sum_q + in_data;
`endif

    // Handshake ready decoded from the registered state
    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            S_LEN:   in_ready = 1'b1;
            S_LOAD:  in_ready = 1'b1;
`ifdef BOOT_CHECKSUM_EN
            S_CHK:   in_ready = 1'b1;
`endif
            default: in_ready = 1'b0;
        endcase
    end

    // Next-state, write pipeline and status computation
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        wr_en_d   = 1'b0;
        wr_adr_d  = wr_adr_q;
        wr_data_d = wr_data_q;
`ifdef BOOT_CHECKSUM_EN
        sum_d     = sum_q;
`endif
        case (state_q)
            S_LEN: begin
                if (xfer_s) begin
                    len_d = in_data;
                    cnt_d = 8'd0;
`ifdef BOOT_CHECKSUM_EN
                    sum_d = in_data;
`endif
                    if (in_data == 8'd0) begin
                        state_d = S_AFTER_DATA;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else begin
                    state_d = S_LEN;
                end
            end
            S_LOAD: begin
                if (xfer_s) begin
                    wr_en_d   = 1'b1;
                    wr_adr_d  = load_adr_s;
                    wr_data_d = WIDTH'(in_data);
                    cnt_d     = cnt_q + 8'd1;
`ifdef BOOT_CHECKSUM_EN
                    sum_d     = chk_sum_s;
`endif
                    if (cnt_q == len_q - 8'd1) begin
                        state_d = S_AFTER_DATA;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else begin
                    state_d = S_LOAD;
                end
            end
`ifdef BOOT_CHECKSUM_EN
            S_CHK: begin
                if (xfer_s) begin
                    if (chk_sum_s == 8'd0) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_ERR;
                    end
                end else begin
                    state_d = S_CHK;
                end
            end
            S_ERR:   state_d = S_ERR;
`endif
            S_DRAIN: state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            default: state_d = S_LEN;
        endcase
        // Release coincides with the edge entering RUN, never alongside a write.
        cpu_resetn_d = (state_d == S_RUN);
        busy_d       = (state_d != S_RUN);
`ifdef BOOT_CHECKSUM_EN
        err_d        = (state_d == S_ERR);
`else
        err_d        = 1'b0;
`endif
    end

    // State and pipeline registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_LEN;
            cnt_q        <= 8'd0;
            len_q        <= 8'd0;
            wr_en_q      <= 1'b0;
            wr_adr_q     <= '0;
            wr_data_q    <= '0;
            cpu_resetn_q <= 1'b0;
            busy_q       <= 1'b1;
            err_q        <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            sum_q        <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            wr_en_q      <= wr_en_d;
            wr_adr_q     <= wr_adr_d;
            wr_data_q    <= wr_data_d;
            cpu_resetn_q <= cpu_resetn_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
`ifdef BOOT_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    // Memory port ownership: loader pipeline while busy, core pass-through after
    always_comb begin
        if (busy_q) begin
            mem_memwrite  = wr_en_q;
            mem_adr       = wr_adr_q;
            mem_writedata = wr_data_q;
        end else begin
            mem_memwrite  = cpu_memwrite;
            mem_adr       = cpu_adr;
            mem_writedata = cpu_writedata;
        end
    end

    assign cpu_resetn = cpu_resetn_q;
    assign busy       = busy_q;
    assign err        = err_q;

endmodule

// File: tb/tb_mem_boot_loader.sv
// Bench for mem_boot_loader: two instances (start 0 and 254) share one input stream.
// Rows of {stimulus, expected outputs} feed a scoreboard queue popped one cycle later.
module tb_mem_boot_loader;

    logic       clk;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       cpu_memwrite;
    logic [7:0] cpu_adr;
    logic [7:0] cpu_writedata;

    logic       rdy_a, we_a, rn_a, busy_a, err_a;
    logic [7:0] adr_a, wd_a;
    logic       rdy_b, we_b, rn_b, busy_b, err_b;
    logic [7:0] adr_b, wd_b;

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];

    int errors = 0;
    int checks = 0;

`ifdef BOOT_CHECKSUM_EN
    localparam logic RA = 1'b1;
`else
    localparam logic RA = 1'b0;
`endif

    typedef struct packed {
        logic       rst;
        logic       vld;
        logic [7:0] d;
        logic       rdy;
        logic       rn;
        logic       bsy;
        logic       er;
        logic       we;
        logic [7:0] off;
        logic [7:0] wd;
        logic [3:0] post;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    mem_boot_loader #(.WIDTH(8), .START_ADR(0)) dut_a (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_a),
        .cpu_memwrite(cpu_memwrite), .cpu_adr(cpu_adr), .cpu_writedata(cpu_writedata),
        .mem_memwrite(we_a), .mem_adr(adr_a), .mem_writedata(wd_a),
        .cpu_resetn(rn_a), .busy(busy_a), .err(err_a)
    );

    mem_boot_loader #(.WIDTH(8), .START_ADR(254)) dut_b (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_b),
        .cpu_memwrite(cpu_memwrite), .cpu_adr(cpu_adr), .cpu_writedata(cpu_writedata),
        .mem_memwrite(we_b), .mem_adr(adr_b), .mem_writedata(wd_b),
        .cpu_resetn(rn_b), .busy(busy_b), .err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (we_a) mem_a[adr_a] <= wd_a;
        if (we_b) mem_b[adr_b] <= wd_b;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic vld, input logic [7:0] d,
                       input logic rdy, input logic rn, input logic bsy, input logic er,
                       input logic we, input logic [7:0] off, input logic [7:0] wd,
                       input logic [3:0] post);
        vec_t v;
        v = '{rst: rst, vld: vld, d: d, rdy: rdy, rn: rn, bsy: bsy, er: er,
              we: we, off: off, wd: wd, post: post};
        vecs.push_back(v);
    endtask

    task automatic post_checks(input logic [3:0] code);
        case (code)
            4'd1: begin
                chk("basic mem_a[0]", mem_a[0], 8'hA1);
                chk("basic mem_a[1]", mem_a[1], 8'hB2);
                chk("basic mem_a[2]", mem_a[2], 8'hC3);
                chk("basic mem_b[254]", mem_b[254], 8'hA1);
                chk("basic mem_b[255]", mem_b[255], 8'hB2);
                chk("basic mem_b[0]", mem_b[0], 8'hC3);
                cpu_adr = 8'h3C; cpu_writedata = 8'h55; cpu_memwrite = 1'b1;
                in_valid = 1'b1; in_data = 8'h42;
                #1;
                chk("pass we_a", we_a, 1'b1);
                chk("pass adr_a", adr_a, 8'h3C);
                chk("pass wd_a", wd_a, 8'h55);
                chk("pass adr_b", adr_b, 8'h3C);
                chk("pass ready_a", rdy_a, 1'b0);
                @(posedge clk);
                @(negedge clk);
                chk("pass ready_a later", rdy_a, 1'b0);
                chk("pass resetn_a", rn_a, 1'b1);
                chk("pass mem_a[3c]", mem_a[8'h3C], 8'h55);
                cpu_memwrite = 1'b0; in_valid = 1'b0;
            end
            4'd2: begin
                chk("stall mem_a[0]", mem_a[0], 8'hA1);
                chk("stall mem_a[1]", mem_a[1], 8'hB2);
                chk("stall mem_a[2]", mem_a[2], 8'hC3);
            end
            4'd3: begin
                chk("wrap mem_b[254]", mem_b[254], 8'h01);
                chk("wrap mem_b[255]", mem_b[255], 8'h02);
                chk("wrap mem_b[0]", mem_b[0], 8'h03);
                chk("wrap mem_b[1]", mem_b[1], 8'h04);
                chk("wrap mem_a[3]", mem_a[3], 8'h04);
            end
            4'd4: begin
                chk("midrst mem_a[0]", mem_a[0], 8'h77);
                chk("midrst mem_a[1]", mem_a[1], 8'h22);
                chk("midrst mem_b[254]", mem_b[254], 8'h77);
            end
            default: ;
        endcase
    endtask

    initial begin
        vec_t e;
        logic [7:0] exp_b;
        reset = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        cpu_memwrite = 1'b0; cpu_adr = 8'h00; cpu_writedata = 8'h00;

        // Basic load: 3, A1, B2, C3 back-to-back
        add(0,0,8'h00, 1,0,1,0, 0,8'hFF,8'h00, 0);
        add(1,1,8'h03, 1,0,1,0, 0,8'hFF,8'h00, 0);
        add(1,1,8'hA1, 1,0,1,0, 1,8'h00,8'hA1, 0);
        add(1,1,8'hB2, 1,0,1,0, 1,8'h01,8'hB2, 0);
        add(1,1,8'hC3, RA,0,1,0, 1,8'h02,8'hC3, 0);
`ifdef BOOT_CHECKSUM_EN
        add(1,1,8'hE7, 0,0,1,0, 0,8'h02,8'h00, 0);
`endif
        add(1,0,8'hEE, 0,1,0,0, 0,8'hFF,8'h00, 1);
        // Stalled source between data bytes
        add(0,0,8'h00, 1,0,1,0, 0,8'hFF,8'h00, 0);
        add(1,1,8'h03, 1,0,1,0, 0,8'hFF,8'h00, 0);
        add(1,1,8'hA1, 1,0,1,0, 1,8'h00,8'hA1, 0);
        add(1,0,8'hEE, 1,0,1,0, 0,8'h00,8'h00, 0);
        add(1,0,8'hEE, 1,0,1,0, 0,8'h00,8'h00, 0);
        add(1,1,8'hB2, 1,0,1,0, 1,8'h01,8'hB2, 0);
        add(1,0,8'hEE, 1,0,1,0, 0,8'h01,8'h00, 0);
        add(1,0,8'hEE, 1,0,1,0, 0,8'h01,8'h00, 0);
        add(1,1,8'hC3, RA,0,1,0, 1,8'h02,8'hC3, 0);
`ifdef BOOT_CHECKSUM_EN
        add(1,1,8'hE7, 0,0,1,0, 0,8'h02,8'h00, 0);
`endif
        add(1,0,8'hEE, 0,1,0,0, 0,8'hFF,8'h00, 2);
        // Wrap-around image, then in_valid held high in RUN
        add(0,0,8'h00, 1,0,1,0, 0,8'hFF,8'h00, 0);
        add(1,1,8'h04, 1,0,1,0, 0,8'hFF,8'h00, 0);
        add(1,1,8'h01, 1,0,1,0, 1,8'h00,8'h01, 0);
        add(1,1,8'h02, 1,0,1,0, 1,8'h01,8'h02, 0);
        add(1,1,8'h03, 1,0,1,0, 1,8'h02,8'h03, 0);
        add(1,1,8'h04, RA,0,1,0, 1,8'h03,8'h04, 0);
`ifdef BOOT_CHECKSUM_EN
        add(1,1,8'hF2, 0,0,1,0, 0,8'h03,8'h00, 0);
`endif
        add(1,0,8'hEE, 0,1,0,0, 0,8'hFF,8'h00, 3);
        add(1,1,8'h99, 0,1,0,0, 0,8'hFF,8'h00, 0);
        add(1,1,8'h98, 0,1,0,0, 0,8'hFF,8'h00, 0);
        // Zero-length image
        add(0,0,8'h00, 1,0,1,0, 0,8'hFF,8'h00, 0);
        add(1,1,8'h00, RA,0,1,0, 0,8'hFF,8'h00, 0);
`ifdef BOOT_CHECKSUM_EN
        add(1,1,8'h00, 0,0,1,0, 0,8'hFF,8'h00, 0);
`endif
        add(1,0,8'hEE, 0,1,0,0, 0,8'hFF,8'h00, 0);
        // Reset in the middle of a load, then a new one-byte image
        add(0,0,8'h00, 1,0,1,0, 0,8'hFF,8'h00, 0);
        add(1,1,8'h05, 1,0,1,0, 0,8'hFF,8'h00, 0);
        add(1,1,8'h11, 1,0,1,0, 1,8'h00,8'h11, 0);
        add(1,1,8'h22, 1,0,1,0, 1,8'h01,8'h22, 0);
        add(0,1,8'h33, 1,0,1,0, 0,8'hFF,8'h00, 0);
        add(1,1,8'h01, 1,0,1,0, 0,8'hFF,8'h00, 0);
        add(1,1,8'h77, RA,0,1,0, 1,8'h00,8'h77, 0);
`ifdef BOOT_CHECKSUM_EN
        add(1,1,8'h88, 0,0,1,0, 0,8'h00,8'h00, 0);
`endif
        add(1,0,8'hEE, 0,1,0,0, 0,8'hFF,8'h00, 4);
`ifdef BOOT_CHECKSUM_EN
        // Bad checksum locks in ERR until reset, then a good image boots
        add(0,0,8'h00, 1,0,1,0, 0,8'hFF,8'h00, 0);
        add(1,1,8'h02, 1,0,1,0, 0,8'hFF,8'h00, 0);
        add(1,1,8'h10, 1,0,1,0, 1,8'h00,8'h10, 0);
        add(1,1,8'h20, 1,0,1,0, 1,8'h01,8'h20, 0);
        add(1,1,8'hCF, 0,0,1,1, 0,8'h01,8'h00, 0);
        add(1,1,8'hCE, 0,0,1,1, 0,8'h01,8'h00, 0);
        add(0,0,8'h00, 1,0,1,0, 0,8'hFF,8'h00, 0);
        add(1,1,8'h02, 1,0,1,0, 0,8'hFF,8'h00, 0);
        add(1,1,8'h10, 1,0,1,0, 1,8'h00,8'h10, 0);
        add(1,1,8'h20, 1,0,1,0, 1,8'h01,8'h20, 0);
        add(1,1,8'hCE, 0,0,1,0, 0,8'h01,8'h00, 0);
        add(1,0,8'hEE, 0,1,0,0, 0,8'hFF,8'h00, 0);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            reset    = vecs[i].rst;
            in_valid = vecs[i].vld;
            in_data  = vecs[i].d;
            sb.push_back(vecs[i]);
            @(posedge clk);
            @(negedge clk);
            e = sb.pop_front();
            chk($sformatf("r%0d ready_a", i), rdy_a, e.rdy);
            chk($sformatf("r%0d ready_b", i), rdy_b, e.rdy);
            chk($sformatf("r%0d resetn_a", i), rn_a, e.rn);
            chk($sformatf("r%0d resetn_b", i), rn_b, e.rn);
            chk($sformatf("r%0d busy_a", i), busy_a, e.bsy);
            chk($sformatf("r%0d err_a", i), err_a, e.er);
            chk($sformatf("r%0d we_a", i), we_a, e.we);
            chk($sformatf("r%0d we_b", i), we_b, e.we);
            exp_b = 8'd254 + e.off;
            if (e.we || (e.bsy && e.off != 8'hFF)) begin
                chk($sformatf("r%0d adr_a", i), adr_a, e.off);
                chk($sformatf("r%0d adr_b", i), adr_b, exp_b);
            end
            if (e.we) begin
                chk($sformatf("r%0d wd_a", i), wd_a, e.wd);
                chk($sformatf("r%0d wd_b", i), wd_b, e.wd);
            end
            post_checks(e.post);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
